// File: rtl/twophase_arb_pkg.sv
// Shared types and helpers for the two-phase round-robin share arbiter.
package twophase_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } arb_state_t;

    // Grant-index width; a single requester still needs one bit.
    function automatic int idw_of(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/twophase_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first pending index after last_grant, modulo N_REQ.
module rr_pick
    import twophase_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDW   = idw_of(N_REQ)
) (
    input  logic [N_REQ-1:0] pend,
    input  logic [IDW-1:0]   last_grant,
    output logic             any,
    output logic [IDW-1:0]   winner
);

    assign any = |pend;

    // Scan farthest-first so the nearest pending channel after last_grant overwrites.
    always_comb begin
        winner = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (pend[(int'(last_grant) + k) % N_REQ]) begin
                winner = IDW'((int'(last_grant) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/twophase_share_arbiter.sv
// Shares one two-phase resource channel between N_REQ two-phase requesters, round-robin.
// Define ARB_SYNC_EN to add 2-flop synchronizers on a_req and b_ack.
module twophase_share_arbiter
    import twophase_arb_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int N_REQ = 2,
    parameter int IDW   = idw_of(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       a_req,
    input  logic [N_REQ*WIDTH-1:0] a_data,
    output logic [N_REQ-1:0]       a_ack,
    output logic                   b_req,
    output logic [WIDTH-1:0]       b_data,
    output logic [IDW-1:0]         b_sel,
    input  logic                   b_ack,
    output logic                   busy
);

    arb_state_t         state;
    logic [IDW-1:0]     last_grant;
    logic [N_REQ-1:0]   a_req_s;
    logic               b_ack_s;
    logic [N_REQ-1:0]   pend;
    logic               any;
    logic [IDW-1:0]     winner;
    logic [WIDTH-1:0]   ch_data [N_REQ];

`ifdef ARB_SYNC_EN
    logic [N_REQ-1:0]   a_req_m;
    logic               b_ack_m;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_req_m <= '0;
            a_req_s <= '0;
            b_ack_m <= 1'b0;
            b_ack_s <= 1'b0;
        end else begin
            a_req_m <= a_req;
            a_req_s <= a_req_m;
            b_ack_m <= b_ack;
            b_ack_s <= b_ack_m;
        end
    end
`else
    assign a_req_s = a_req;
    assign b_ack_s = b_ack;
`endif

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_chan
            assign ch_data[gi] = a_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // A channel is pending while its request toggle differs from our ack toggle.
    assign pend = a_req_s ^ a_ack;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .pend       (pend),
        .last_grant (last_grant),
        .any        (any),
        .winner     (winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            a_ack      <= '0;
            b_req      <= 1'b0;
            b_data     <= '0;
            b_sel      <= '0;
            busy       <= 1'b0;
            last_grant <= IDW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        b_data <= ch_data[winner];
                        b_sel  <= winner;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                // Data was latched a cycle earlier, giving bundled-data setup before the toggle.
                ISSUE: begin
                    b_req <= ~b_req;
                    state <= WAIT;
                end
                WAIT: begin
                    if (b_ack_s == b_req) begin
                        state <= RETURN;
                    end
                end
                RETURN: begin
                    a_ack[b_sel] <= ~a_ack[b_sel];
                    last_grant   <= b_sel;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_twophase_share_arbiter.sv
// Directed bench for twophase_share_arbiter with a transaction-level reference model.
module tb_twophase_share_arbiter;

    localparam int WIDTH = 12;
    localparam int N_REQ = 2;
`ifdef ARB_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [1:0]         a_req = '0;
    logic [23:0]        a_data = '0;
    logic [1:0]         a_ack;
    logic               b_req;
    logic [11:0]        b_data;
    logic [0:0]         b_sel;
    logic               b_ack = 1'b0;
    logic               busy;

    int errors = 0;
    int checks = 0;
    logic model_on = 1'b0;

    always #5 clk = ~clk;

    twophase_share_arbiter #(
        .WIDTH (WIDTH),
        .N_REQ (N_REQ)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .a_req  (a_req),
        .a_data (a_data),
        .a_ack  (a_ack),
        .b_req  (b_req),
        .b_data (b_data),
        .b_sel  (b_sel),
        .b_ack  (b_ack),
        .busy   (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: one service at a time -----------------
    logic [1:0]  m_hist0, m_hist1;
    logic        m_bh0, m_bh1;
    int          m_serv;        // channel being served, -1 when none
    int          m_step;        // 0: toggle pending, 1: awaiting done, 2: ack pending
    logic [1:0]  m_ack;
    logic        m_breq;
    logic [11:0] m_data;
    int          m_sel;
    int          m_last;

    always @(posedge clk or negedge reset) begin
        logic [1:0] seen_req;
        logic       seen_back;
        int         w;
        if (!reset) begin
            m_hist0 <= '0; m_hist1 <= '0; m_bh0 <= 1'b0; m_bh1 <= 1'b0;
            m_serv <= -1; m_step <= 0; m_ack <= '0; m_breq <= 1'b0;
            m_data <= '0; m_sel <= 0; m_last <= N_REQ - 1;
        end else begin
`ifdef ARB_SYNC_EN
            seen_req  = m_hist1;
            seen_back = m_bh1;
`else
            seen_req  = a_req;
            seen_back = b_ack;
`endif
            m_hist1 <= m_hist0; m_hist0 <= a_req;
            m_bh1   <= m_bh0;   m_bh0   <= b_ack;
            if (m_serv < 0) begin
                w = -1;
                for (int k = 1; k <= N_REQ; k++) begin
                    if (w < 0 && (seen_req[(m_last + k) % N_REQ] != m_ack[(m_last + k) % N_REQ]))
                        w = (m_last + k) % N_REQ;
                end
                if (w >= 0) begin
                    m_serv <= w;
                    m_step <= 0;
                    m_sel  <= w;
                    m_data <= a_data[w*WIDTH +: WIDTH];
                end
            end else if (m_step == 0) begin
                m_breq <= ~m_breq;
                m_step <= 1;
            end else if (m_step == 1) begin
                if (seen_back == m_breq) m_step <= 2;
            end else begin
                m_ack[m_serv] <= ~m_ack[m_serv];
                m_last <= m_serv;
                m_serv <= -1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on && reset === 1'b1) begin
            check("model_b_req", 32'(b_req), 32'(m_breq));
            check("model_b_data", 32'(b_data), 32'(m_data));
            check("model_b_sel", 32'(b_sel), 32'(m_sel));
            check("model_a_ack", 32'(a_ack), 32'(m_ack));
            check("model_busy", 32'(busy), 32'(m_serv >= 0));
        end
    end

    // ---------------- helpers -----------------
    task automatic wait_breq(output int edges);
        logic prev;
        prev  = b_req;
        edges = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (b_req !== prev) begin
                edges = k;
                break;
            end
        end
        checks++;
        if (edges < 0) begin
            errors++;
            $display("FAIL b_req_timeout: got no toggle required toggle within 40 cycles");
        end
    endtask

    task automatic wait_aack(output int edges);
        logic [1:0] prev;
        prev  = a_ack;
        edges = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (a_ack !== prev) begin
                edges = k;
                break;
            end
        end
        checks++;
        if (edges < 0) begin
            errors++;
            $display("FAIL a_ack_timeout: got no toggle required toggle within 40 cycles");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        a_req  = '0;
        b_ack  = 1'b0;
        a_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic toggle_back();
        @(negedge clk);
        b_ack = ~b_ack;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish by 200us");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        int sel_exp [4] = '{0, 1, 0, 1};
        logic [11:0] data_exp [2] = '{12'h111, 12'h222};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_b_req", 32'(b_req), 32'h0);
        check("reset_a_ack", 32'(a_ack), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        model_on = 1'b1;

        // Single request and latency
        @(negedge clk);
        a_data[11:0] = 12'h05A;
        a_req[0] = 1'b1;
        wait_breq(e);
        check("t1_req_latency", 32'(e), 32'(LAT));
        check("t1_b_data", 32'(b_data), 32'h05A);
        check("t1_b_sel", 32'(b_sel), 32'h0);
        check("t1_busy", 32'(busy), 32'h1);
        toggle_back();
        wait_aack(e);
        check("t1_ack_latency", 32'(e), 32'(LAT));
        check("t1_a_ack", 32'(a_ack), 32'h1);
        @(negedge clk);
        check("t1_idle", 32'(busy), 32'h0);
        $display("txn single: b_data=%h b_sel=%0d a_ack=%b", b_data, b_sel, a_ack);

        // Simultaneous requests
        do_reset();
        @(negedge clk);
        a_data = {12'hFFF, 12'h123};
        a_req  = 2'b11;
        wait_breq(e);
        check("t2_first_data", 32'(b_data), 32'h123);
        check("t2_first_sel", 32'(b_sel), 32'h0);
        $display("txn simul grant: b_data=%h b_sel=%0d", b_data, b_sel);
        toggle_back();
        wait_breq(e);
        check("t2_second_data", 32'(b_data), 32'hFFF);
        check("t2_second_sel", 32'(b_sel), 32'h1);
        $display("txn simul grant: b_data=%h b_sel=%0d", b_data, b_sel);
        toggle_back();
        wait_aack(e);
        check("t2_a_ack", 32'(a_ack), 32'h3);

        // Fairness under continuous requests
        do_reset();
        @(negedge clk);
        a_data = {data_exp[1], data_exp[0]};
        a_req  = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_breq(e);
            check($sformatf("t3_sel_%0d", g), 32'(b_sel), 32'(sel_exp[g]));
            check($sformatf("t3_data_%0d", g), 32'(b_data), 32'(data_exp[sel_exp[g]]));
            $display("txn fairness grant %0d: b_sel=%0d b_data=%h", g, b_sel, b_data);
            toggle_back();
            wait_aack(e);
            @(negedge clk);
            a_req[b_sel] = ~a_req[b_sel];
        end

        // Reset mid-WAIT
        do_reset();
        @(negedge clk);
        a_data[11:0] = 12'h7E7;
        a_req[0] = 1'b1;
        wait_breq(e);
        @(negedge clk);
        reset = 1'b0;
        a_req = '0;
        b_ack = 1'b0;
        #1;
        check("t4_rst_b_req", 32'(b_req), 32'h0);
        check("t4_rst_b_data", 32'(b_data), 32'h0);
        check("t4_rst_b_sel", 32'(b_sel), 32'h0);
        check("t4_rst_a_ack", 32'(a_ack), 32'h0);
        check("t4_rst_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        a_data[23:12] = 12'h3C3;
        a_req[1] = 1'b1;
        wait_breq(e);
        check("t4_sel", 32'(b_sel), 32'h1);
        check("t4_data", 32'(b_data), 32'h3C3);
        toggle_back();
        wait_aack(e);
        check("t4_a_ack", 32'(a_ack), 32'h2);
        $display("txn after reset: b_sel=%0d b_data=%h a_ack=%b", b_sel, b_data, a_ack);

        // Spurious ack while idle
        do_reset();
        @(negedge clk);
        b_ack = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_idle_b_req", 32'(b_req), 32'h0);
        check("t5_idle_a_ack", 32'(a_ack), 32'h0);
        check("t5_idle_busy", 32'(busy), 32'h0);
        a_data[11:0] = 12'h0A5;
        a_req[0] = 1'b1;
        wait_breq(e);
        check("t5_data", 32'(b_data), 32'h0A5);
        wait_aack(e);
        check("t5_early_done", 32'(e), 32'h1);
        check("t5_a_ack", 32'(a_ack), 32'h1);
        $display("txn spurious ack: b_data=%h a_ack=%b", b_data, a_ack);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
